// File: rtl/operand_fetch_stage_if.sv
// Pipeline slot between operand fetch and execute: registered payload plus
// out_valid/out_ready handshake.
interface operand_fetch_stage_if;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_dr;
    logic        out_rw;
    logic        out_load;
    logic [31:0] out_a;
    logic [31:0] out_b;

    // Handshake: the slot is taken by execute on any rising edge where
    // out_valid & out_ready; while out_valid & !out_ready every out_* holds.
    modport master (
        output out_valid, out_opcode, out_dr, out_rw, out_load, out_a, out_b,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_opcode, out_dr, out_rw, out_load, out_a, out_b,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: splits the instruction, drives register file
// read addresses, forwards from EX/WB, and inserts bubbles on load-use.
module operand_fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic [4:0]  AA,
    output logic [4:0]  BA,
    input  logic [31:0] A_data,
    input  logic [31:0] B_data,
    input  logic        ex_valid,
    input  logic        ex_wr,
    input  logic        ex_load,
    input  logic [4:0]  ex_dr,
    input  logic [31:0] ex_result,
    input  logic        wb_wr,
    input  logic [4:0]  wb_dr,
    input  logic [31:0] wb_data,
    operand_fetch_stage_if.master slot,
    output logic [15:0] stall_cnt
);
    logic [6:0]  opcode;
    logic [4:0]  dr;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [14:0] imm;
    logic        imm_sel;
    logic        rw;
    logic        load;
    logic        ex_fwd_ok;
    logic        hazard;
    logic        slot_free;
    logic        accept;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign opcode  = instr[31:25];
    assign dr      = instr[24:20];
    assign sa      = instr[19:15];
    assign sb      = instr[14:10];
    assign imm     = instr[14:0];
    assign imm_sel = opcode[6];
    assign rw      = opcode[5];
    assign load    = (opcode == 7'h21);

    assign AA = sa;
    assign BA = sb;

    // A load in EX has no data yet, so it is never a forwarding source.
    assign ex_fwd_ok = ex_valid & ex_wr & ~ex_load;

    assign hazard = in_valid & ex_valid & ex_wr & ex_load &
                    ((ex_dr == sa) | (~imm_sel & (ex_dr == sb)));

    assign slot_free = ~slot.out_valid | slot.out_ready;
    assign in_ready  = flush | (slot_free & ~hazard);
    assign accept    = ~flush & slot_free & in_valid & ~hazard;

    always_comb begin
        op_a = A_data;
        if (ex_fwd_ok && ex_dr == sa)
            op_a = ex_result;
        else if (wb_wr && wb_dr == sa)
            op_a = wb_data;
    end

    always_comb begin
        op_b = B_data;
        if (imm_sel)
            op_b = {{17{imm[14]}}, imm};
        else if (ex_fwd_ok && ex_dr == sb)
            op_b = ex_result;
        else if (wb_wr && wb_dr == sb)
            op_b = wb_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot.out_valid  <= 1'b0;
            slot.out_opcode <= 7'd0;
            slot.out_dr     <= 5'd0;
            slot.out_rw     <= 1'b0;
            slot.out_load   <= 1'b0;
            slot.out_a      <= 32'd0;
            slot.out_b      <= 32'd0;
        end else if (flush) begin
            slot.out_valid <= 1'b0;
        end else if (accept) begin
            slot.out_valid  <= 1'b1;
            slot.out_opcode <= opcode;
            slot.out_dr     <= dr;
            slot.out_rw     <= rw;
            slot.out_load   <= load;
            slot.out_a      <= op_a;
            slot.out_b      <= op_b;
        end else if (slot_free) begin
            // Bubble or idle: payload is left as-is, only valid drops.
            slot.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= 16'd0;
        else if (hazard && slot_free && !flush && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
endmodule
